// File: rtl/coin_input_encoder.sv
// coin_input_encoder
//   Turns four noisy vending-machine sensors into a serial stream of one-hot
//   event codes. Each input is synchronized and debounced. A rising debounced
//   level queues a pending event. A small arbiter issues one event at a time,
//   choosing by fixed priority RETBUT > COFFEE > IN100 > IN050, and follows
//   each event with GAP_CYCLES idle cycles.
//
//   Ports
//     clock       system clock, rising edge
//     reset       asynchronous, active-high
//     raw_in050   50-won coin sensor (async)
//     raw_in100   100-won coin sensor (async)
//     raw_coffee  coffee button (async)
//     raw_retbut  return button (async)
//     inpco[3:0]  one-hot event, valid for the single ISSUE cycle
//     busy        FSM in ISSUE or GAP
//     drop_err    sticky: a press arrived while the same channel was still pending
//     ev_count    issued events, modulo 256

// Per-channel front end: 2-flop synchronizer, debounce counter, and a
// registered rising-edge pulse of the debounced level.
module coin_input_encoder_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1, sync2;
  logic       deb, deb_d;
  logic [7:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      deb   <= 1'b0;
      deb_d <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      // Edge pulse is registered so the arbiter sees a clean one-cycle flag.
      rise  <= deb & ~deb_d;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // The counter never actually holds DEBOUNCE_CYCLES. It clears on the
        // same edge that accepts the new level.
        cnt <= '0;
        deb <= ~deb;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

module coin_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int GAP_CYCLES      = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       raw_in050,
  input  logic       raw_in100,
  input  logic       raw_coffee,
  input  logic       raw_retbut,
  output logic [3:0] inpco,
  output logic       busy,
  output logic       drop_err,
  output logic [7:0] ev_count
);
  localparam int         NUM_LANES = 4;
  localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                 state, nxt;
  logic [NUM_LANES-1:0]   raw, rise, pend, win, win_r, clr;
  logic [3:0]             gcnt;

  // Bit position doubles as the one-hot output code.
  assign raw = {raw_retbut, raw_coffee, raw_in100, raw_in050};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
    coin_input_encoder_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .clock (clock),
      .reset (reset),
      .raw   (raw[i]),
      .rise  (rise[i])
    );
  end

  // Fixed priority: highest bit wins.
  always_comb begin
    win = '0;
    if      (pend[3]) win = 4'b1000;
    else if (pend[2]) win = 4'b0100;
    else if (pend[1]) win = 4'b0010;
    else if (pend[0]) win = 4'b0001;
  end

  always_comb begin
    nxt = state;
    clr = '0;
    case (state)
      IDLE:  if (|pend) begin
               nxt = ISSUE;
               clr = win;
             end
      ISSUE: nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   if (gcnt == GAP_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pend     <= '0;
      win_r    <= '0;
      gcnt     <= '0;
      drop_err <= 1'b0;
      ev_count <= '0;
    end else begin
      state <= nxt;
      // A press landing on the arbitration edge is kept for the next round.
      // A press landing on a still-pending channel is lost and flagged.
      pend     <= (pend & ~clr) | rise;
      drop_err <= drop_err | (|(rise & pend & ~clr));
      if (state == IDLE) win_r <= win;
      gcnt     <= (state == GAP) ? gcnt + 4'd1 : 4'd0;
      ev_count <= ev_count + 8'(state == ISSUE);
    end
  end

  assign inpco = (state == ISSUE) ? win_r : 4'b0000;
  assign busy  = (state != IDLE);
endmodule

// File: doc/coin_input_encoder.md
COIN_INPUT_ENCODER -- requirements
Module: coin_input_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, cycles a synchronized raw level must stay stable before acceptance; legal range 1..255.
REQ-002 Parameter GAP_CYCLES, default 2, all-zero idle cycles forced after every issued event; legal range 0..15.
REQ-003 clock  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 raw_in050  input  1  unsynchronized 50-won coin sensor, high while the coin is present.
REQ-006 raw_in100  input  1  unsynchronized 100-won coin sensor, high while the coin is present.
REQ-007 raw_coffee  input  1  unsynchronized coffee button, high while pressed.
REQ-008 raw_retbut  input  1  unsynchronized return button, high while pressed.
REQ-009 inpco  output  4  one-hot event code: 0001 IN050, 0010 IN100, 0100 COFFEE, 1000 RETBUT, 0000 no event.
REQ-010 busy  output  1  high while the FSM is in ISSUE or GAP.
REQ-011 drop_err  output  1  sticky flag, set when an accepted press is lost.
REQ-012 ev_count  output  8  count of issued events, modulo 256.

Function
REQ-013 Each raw input SHALL pass through a dedicated two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL have an 8-bit debounce counter and a debounced level deb.
  - Counter clears whenever sync == deb.
  - Counter increments whenever sync != deb.
  - deb toggles, and the counter clears, on the cycle the counter would reach DEBOUNCE_CYCLES.
REQ-015 A 0->1 transition of deb SHALL set that channel's pending bit on the next clock edge; 1->0 transitions SHALL produce no event.
REQ-016 If a 0->1 deb transition occurs while that channel's pending bit is already set, the new press SHALL be discarded and drop_err SHALL be set.
REQ-017 The FSM SHALL have three states: IDLE, ISSUE and GAP.
  - IDLE -> ISSUE when any pending bit is set.
  - ISSUE -> GAP when GAP_CYCLES > 0; ISSUE -> IDLE when GAP_CYCLES == 0.
  - GAP -> IDLE after exactly GAP_CYCLES cycles in GAP.
REQ-018 In IDLE, the winning pending channel SHALL be selected by fixed priority RETBUT > COFFEE > IN100 > IN050, registered, and its pending bit cleared on the IDLE->ISSUE edge.
REQ-019 inpco SHALL equal the registered winner's one-hot code for exactly the one cycle the FSM is in ISSUE, and 0000 in every other cycle; inpco SHALL never have more than one bit set.
REQ-020 Pending bits that lose arbitration SHALL be retained and issued in later IDLE->ISSUE cycles in priority order.
REQ-021 A pending bit setting in the same cycle as the IDLE->ISSUE edge SHALL participate in the next arbitration only.
REQ-022 ev_count SHALL increment by 1 in every ISSUE cycle and SHALL wrap from 255 to 0.
REQ-023 Latency from the first rising clock edge that samples a raw input high (FSM in IDLE, nothing pending, deb low, raw stable) to inpco assertion SHALL be DEBOUNCE_CYCLES+4 cycles.
REQ-024 A raw pulse shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no event and SHALL not set drop_err.

Reset
REQ-025 While reset is high, the following SHALL be forced immediately, independent of clock: synchronizers, deb levels and debounce counters to 0; pending bits cleared; FSM to IDLE; inpco = 0000; busy = 0; drop_err = 0; ev_count = 0.
REQ-026 Reset asserted mid-ISSUE or mid-GAP SHALL abort the event and discard all pending events.
REQ-027 After reset deasserts, an input already held high SHALL be treated as a new press, giving one event after the REQ-023 latency.

Verification
REQ-028 Single coin, defaults: raw_in050 held high 20 cycles -> inpco = 0001 for exactly one cycle, 8 cycles after the first sampling edge; ev_count = 1; busy high 3 cycles.
REQ-029 Glitch: raw_in100 high for 3 cycles, DEBOUNCE_CYCLES = 4 -> inpco stays 0000; ev_count = 0; drop_err = 0.
REQ-030 Simultaneous press: all four raw inputs rise together and are held -> inpco sequence 1000, 0100, 0010, 0001, each separated by exactly 2 zero cycles plus 1 IDLE cycle; ev_count = 4.
REQ-031 Overflow: GAP_CYCLES = 15, raw_retbut and raw_coffee pressed together, then raw_coffee released and re-pressed (debounced) before COFFEE issues -> exactly one COFFEE event; drop_err = 1 and stays 1.
REQ-032 Reset mid-operation: assert reset during ISSUE with IN050 pending -> inpco = 0000 and ev_count = 0 immediately; after deassertion with all raw inputs low, no further event.
REQ-033 Wrap: issue 257 coin events -> ev_count = 1.
